// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - two independent synchronize-and-debounce channels
// A level change is accepted only after DEBOUNCE_CYCLES consecutive synchronized samples.

module debounceChannel #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic level,
    output logic chg
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {STABLE, PENDING} stateType;

    stateType         state, nextState;
    logic             s1, s2;
    logic [CNT_W-1:0] cnt, nextCnt;
    logic             nextLevel, nextChg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            state <= STABLE;
            cnt   <= '0;
            level <= 1'b0;
            chg   <= 1'b0;
        end else begin
            s1    <= sw;
            s2    <= s1;
            state <= nextState;
            cnt   <= nextCnt;
            level <= nextLevel;
            chg   <= nextChg;
        end
    end

    // Any sample that agrees with the current level drops back to STABLE with a cleared count.
    always_comb begin
        nextState = STABLE;
        nextCnt   = '0;
        nextLevel = level;
        nextChg   = 1'b0;
        if (s2 != level) begin
            if (state == PENDING && cnt == CNT_LAST) begin
                nextLevel = s2;
                nextChg   = 1'b1;
            end else begin
                nextState = PENDING;
                nextCnt   = (state == STABLE) ? CNT_W'(1) : cnt + CNT_W'(1);
            end
        end
    end
endmodule

module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic swA,
    input  logic swB,
    output logic A,
    output logic B,
    output logic A_chg,
    output logic B_chg
);
    generate
        if (DEBOUNCE_CYCLES < 2) begin : gBadParam
            $error("switch_debouncer: DEBOUNCE_CYCLES must be at least 2");
        end
    endgenerate

    debounceChannel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) chanA (
        .clk   (clk),
        .rst   (rst),
        .sw    (swA),
        .level (A),
        .chg   (A_chg)
    );

    debounceChannel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) chanB (
        .clk   (clk),
        .rst   (rst),
        .sw    (swB),
        .level (B),
        .chg   (B_chg)
    );
endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - directed table, corner sequences and randomized model check
module tb_switch_debouncer;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic swA = 1'b0;
    logic swB = 1'b0;
    logic A, B, A_chg, B_chg;

    int total  = 0;
    int passed = 0;

    switch_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
        .clk   (clk),
        .rst   (rst),
        .swA   (swA),
        .swB   (swB),
        .A     (A),
        .B     (B),
        .A_chg (A_chg),
        .B_chg (B_chg)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, a, b, expA, expB, expAchg, expBchg;
    } vecT;
    vecT vecs[$];

    // Reference: each channel remembers its last D+1 raw samples; the level flips when the
    // D samples that reached the synchronizer output ahead of this edge all disagree with it.
    bit hist[2][0:D];
    bit modelOut[2];
    bit modelChg[2];

    task automatic modelEdge(input bit r, input bit a, input bit b);
        bit sample[2];
        bit allDiff;
        sample[0] = a;
        sample[1] = b;
        for (int c = 0; c < 2; c++) begin
            if (r) begin
                modelOut[c] = 1'b0;
                modelChg[c] = 1'b0;
                for (int j = 0; j <= D; j++) hist[c][j] = 1'b0;
            end else begin
                allDiff = 1'b1;
                for (int j = 0; j < D; j++)
                    if (hist[c][j] == modelOut[c]) allDiff = 1'b0;
                modelChg[c] = allDiff;
                if (allDiff) modelOut[c] = ~modelOut[c];
                for (int j = 0; j < D; j++) hist[c][j] = hist[c][j+1];
                hist[c][D] = sample[c];
            end
        end
    endtask

    task automatic step(input logic r, input logic a, input logic b);
        @(negedge clk);
        rst = r;
        swA = a;
        swB = b;
        @(posedge clk);
        modelEdge(r, a, b);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic addRun(input int n, input logic r, input logic a, input logic b,
                          input logic ea, input logic eb, input logic eca, input logic ecb);
        vecT v;
        v.rst = r; v.a = a; v.b = b;
        v.expA = ea; v.expB = eb; v.expAchg = eca; v.expBchg = ecb;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        logic bp[5];
        logic aCur, bCur, rCur;

        // reset, then clean press and release on A
        addRun(2, 1, 0, 0, 0, 0, 0, 0);
        addRun(5, 0, 1, 0, 0, 0, 0, 0);
        addRun(1, 0, 1, 0, 1, 0, 1, 0);
        addRun(3, 0, 1, 0, 1, 0, 0, 0);
        addRun(5, 0, 0, 0, 1, 0, 0, 0);
        addRun(1, 0, 0, 0, 0, 0, 1, 0);
        addRun(2, 0, 0, 0, 0, 0, 0, 0);
        // 3-cycle glitch is rejected; a following press needs the full latency
        addRun(3, 0, 1, 0, 0, 0, 0, 0);
        addRun(4, 0, 0, 0, 0, 0, 0, 0);
        addRun(5, 0, 1, 0, 0, 0, 0, 0);
        addRun(1, 0, 1, 0, 1, 0, 1, 0);
        addRun(5, 0, 0, 0, 1, 0, 0, 0);
        addRun(1, 0, 0, 0, 0, 0, 1, 0);
        addRun(1, 0, 0, 0, 0, 0, 0, 0);
        // both channels together, reset while high, re-rise, joint release
        addRun(5, 0, 1, 1, 0, 0, 0, 0);
        addRun(1, 0, 1, 1, 1, 1, 1, 1);
        addRun(2, 0, 1, 1, 1, 1, 0, 0);
        addRun(1, 1, 1, 1, 0, 0, 0, 0);
        addRun(5, 0, 1, 1, 0, 0, 0, 0);
        addRun(1, 0, 1, 1, 1, 1, 1, 1);
        addRun(5, 0, 0, 0, 1, 1, 0, 0);
        addRun(1, 0, 0, 0, 0, 0, 1, 1);
        addRun(1, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d_A", i), A, vecs[i].expA);
            check($sformatf("vec%0d_B", i), B, vecs[i].expB);
            check($sformatf("vec%0d_A_chg", i), A_chg, vecs[i].expAchg);
            check($sformatf("vec%0d_B_chg", i), B_chg, vecs[i].expBchg);
            if (vecs[i].expA && vecs[i].expB)
                check($sformatf("vec%0d_and", i), int'(A & B), 1);
        end

        // bounce 1,0,1,0,1 then held high: rise 5 edges after the last rising sample
        bp[0] = 1; bp[1] = 0; bp[2] = 1; bp[3] = 0; bp[4] = 1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, bp[i], 0);
            check($sformatf("bounce_low%0d", i), A, 0);
            pulses += int'(A_chg);
        end
        for (int i = 1; i <= 7; i++) begin
            step(0, 1, 0);
            check($sformatf("bounce_edge%0d", i), A, (i >= 5) ? 1 : 0);
            pulses += int'(A_chg);
        end
        check("bounce_pulses", pulses, 1);
        for (int i = 0; i < 7; i++) step(0, 0, 0);
        check("bounce_released", A, 0);

        // reset mid-count on B: rst at k+3 discards the count, rise lands at k+9
        step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 1);
        step(1, 0, 1);
        check("rstmid_B_k3", B, 0);
        for (int i = 4; i <= 9; i++) begin
            step(0, 0, 1);
            check($sformatf("rstmid_B_k%0d", i), B, (i == 9) ? 1 : 0);
            check($sformatf("rstmid_Bchg_k%0d", i), B_chg, (i == 9) ? 1 : 0);
        end
        step(0, 0, 1);
        check("rstmid_Bchg_k10", B_chg, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0);

        // randomized slow-changing levels with occasional resets against the model
        aCur = 0;
        bCur = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) aCur = ~aCur;
            if ($urandom_range(0, 5) == 0) bCur = ~bCur;
            rCur = ($urandom_range(0, 199) == 0);
            step(rCur, aCur, bCur);
            check($sformatf("rand%0d_A", i), A, modelOut[0]);
            check($sformatf("rand%0d_B", i), B, modelOut[1]);
            check($sformatf("rand%0d_A_chg", i), A_chg, modelChg[0]);
            check($sformatf("rand%0d_B_chg", i), B_chg, modelChg[1]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
